// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with glitch filter, frame checks and byte FIFO
module ps2_rx_fifo #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd40000,
  parameter int          FILT       = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [15:0]   tmo_cnt;
  logic          push_req;
  logic [7:0]    push_data;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // The filtered level flips on the FILT-th consecutive differing sample.
  assign fall = filt_clk && !clk_s2 && (filt_cnt == FW'(FILT - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT - 1)) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tmo_cnt    <= 16'd0;
      push_req   <= 1'b0;
      push_data  <= 8'h00;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push_req   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= 16'd0;
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_s2) begin
              frame_err <= 1'b1;
            end else if (^{shreg, par_bit}) begin
              push_req  <= 1'b1;
              push_data <= shreg;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled frame is abandoned once the counter saturates at TIMEOUT.
        if (tmo_cnt == TIMEOUT) begin
          state     <= IDLE;
          frame_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end
    end
  end

  assign busy       = (state != IDLE);
  assign valid      = (count != '0);
  assign full       = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop        = rd && valid;
  assign do_push    = push_req && (!full || pop);
  assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout     <= 8'h00;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      rd_ptr   <= rd_ptr_nxt;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      // Bypass the write when the new byte lands at the head.
      if (do_push && (wr_ptr == rd_ptr_nxt)) dout <= push_data;
      else                                   dout <= mem[rd_ptr_nxt];
    end
  end

endmodule
